// File: rtl/puf_challenge_ctrl_if.sv
// Challenge/response bundle between a PUF run controller and its requester.
// Latency: n/a (wires only).
// Backpressure: none; start is a level request sampled by the controller when idle or done.
//   start, seed, puf_response  : requester/PUF -> controller
//   challenge, exciteL/R, busy, done, resp_word : controller -> PUF/requester
interface puf_challenge_ctrl_if #(
  parameter int RESP_BITS = 32
);
  logic                 start;
  logic [31:0]          seed;
  logic                 puf_response;
  logic [31:0]          challenge;
  logic                 exciteL;
  logic                 exciteR;
  logic                 busy;
  logic                 done;
  logic [RESP_BITS-1:0] resp_word;

  modport master (
    output start, seed, puf_response,
    input  challenge, exciteL, exciteR, busy, done, resp_word
  );

  modport slave (
    input  start, seed, puf_response,
    output challenge, exciteL, exciteR, busy, done, resp_word
  );
endinterface

// File: rtl/puf_challenge_ctrl.sv
// Drives a delay PUF: holds a challenge, fires both excitation edges, samples one response bit per challenge.
// Latency: 1 + RESP_BITS*(2*SETTLE_CYCLES+1) cycles from start acceptance to done.
// Backpressure: start is ignored while busy; accepted in IDLE or DONE only.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : slave side of puf_challenge_ctrl_if (start/seed/puf_response in,
//              challenge/exciteL/exciteR/busy/done/resp_word out)
module puf_challenge_ctrl #(
  parameter int SETTLE_CYCLES = 8,
  parameter int RESP_BITS     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  puf_challenge_ctrl_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    FIRE   = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [7:0] CNT_RELOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [5:0] LAST_BIT   = 6'(RESP_BITS - 1);

  state_t               state, state_nxt;
  logic [7:0]           cnt, cnt_nxt;
  logic [5:0]           bit_cnt, bit_nxt;
  logic [31:0]          chal, chal_nxt;
  logic [RESP_BITS-1:0] resp, resp_nxt;
  logic                 sync1, sync2;
  logic                 excite;
  logic                 busy_q, done_q;

  // Shift-left feedback is invertible, so a non-zero challenge never steps to zero.
  function automatic logic [31:0] lfsr_step(input logic [31:0] c);
    return {c[30:0], c[31] ^ c[21] ^ c[1] ^ c[0]};
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_cnt;
    chal_nxt  = chal;
    resp_nxt  = resp;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          chal_nxt  = (bus.seed == 32'd0) ? 32'h0000_0001 : bus.seed;
          bit_nxt   = 6'd0;
          resp_nxt  = '0;
          cnt_nxt   = CNT_RELOAD;
          state_nxt = ARM;
        end
      end
      ARM: begin
        if (cnt == 8'd0) begin
          cnt_nxt   = CNT_RELOAD;
          state_nxt = FIRE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      FIRE: begin
        if (cnt == 8'd0) begin
          state_nxt = SAMPLE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      SAMPLE: begin
        // Shift form also covers RESP_BITS==1 (the old bit is shifted out).
        resp_nxt = (resp << 1) | RESP_BITS'(sync2);
        bit_nxt  = bit_cnt + 6'd1;
        if (bit_cnt == LAST_BIT) begin
          state_nxt = DONE;
        end else begin
          chal_nxt  = lfsr_step(chal);
          cnt_nxt   = CNT_RELOAD;
          state_nxt = ARM;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      bit_cnt <= 6'd0;
      chal    <= 32'd0;
      resp    <= '0;
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      excite  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
      chal    <= chal_nxt;
      resp    <= resp_nxt;
      sync1   <= bus.puf_response;
      sync2   <= sync1;
      // Status flops decode the next state so they change on the same edge as the state.
      excite  <= (state_nxt == FIRE);
      busy_q  <= (state_nxt == ARM) || (state_nxt == FIRE) || (state_nxt == SAMPLE);
      done_q  <= (state_nxt == DONE);
    end
  end

  // One flop feeds both edges so left and right launch from the same clock edge.
  assign bus.exciteL   = excite;
  assign bus.exciteR   = excite;
  assign bus.challenge = chal;
  assign bus.resp_word = resp;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
